// File: rtl/mem_access_if.sv
// Data-bus interface between the MEM stage (master) and the data memory (slave).
interface mem_access_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        sel;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;

    modport master (
        output req, we, addr, sel, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, sel, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: pass-through for ALU ops, one req/ack bus transaction
// per aligned load/store, big-endian lane selection and load extension.
module mem_access #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [4:0]        ex_wd,
    input  logic              ex_wreg,
    input  logic [31:0]       ex_wdata,
    input  logic [3:0]        ex_mem_op,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [31:0]       ex_reg2,
    output logic [4:0]        mem_wd,
    output logic              mem_wreg,
    output logic [31:0]       mem_wdata,
    output logic              stallreq,
    output logic              misalign,
    mem_access_if.master      dbus
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd9;
    localparam logic [3:0] OP_SH  = 4'd10;
    localparam logic [3:0] OP_SW  = 4'd11;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] ABORT = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              is_load, is_store, is_signed;
    logic              sz_byte, sz_half, sz_word;
    logic [1:0]        lsb;
    logic              mis_c, go_c, stall_c;
    logic [3:0]        sel_c;
    logic [31:0]       wdata_c, ld_c;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;

    // Only stall[4] matters to this stage.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[3:0]};

    assign dbus.req   = req_q;
    assign dbus.we    = we_q;
    assign dbus.addr  = addr_q;
    assign dbus.sel   = sel_q;
    assign dbus.wdata = wdata_q;

    // Decode op, alignment, byte enables, store replication and load extraction.
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_signed = 1'b0;
        sz_byte   = 1'b0;
        sz_half   = 1'b0;
        sz_word   = 1'b0;
        case (ex_mem_op)
            OP_LB:  begin is_load  = 1'b1; sz_byte = 1'b1; is_signed = 1'b1; end
            OP_LBU: begin is_load  = 1'b1; sz_byte = 1'b1; end
            OP_LH:  begin is_load  = 1'b1; sz_half = 1'b1; is_signed = 1'b1; end
            OP_LHU: begin is_load  = 1'b1; sz_half = 1'b1; end
            OP_LW:  begin is_load  = 1'b1; sz_word = 1'b1; end
            OP_SB:  begin is_store = 1'b1; sz_byte = 1'b1; end
            OP_SH:  begin is_store = 1'b1; sz_half = 1'b1; end
            OP_SW:  begin is_store = 1'b1; sz_word = 1'b1; end
            default: ;
        endcase

        lsb   = ex_mem_addr[1:0];
        mis_c = (sz_half & lsb[0]) | (sz_word & (|lsb));
        go_c  = (is_load | is_store) & ~mis_c;

        if (sz_byte) begin
            sel_c   = 4'b1000 >> lsb;
            wdata_c = {4{ex_reg2[7:0]}};
        end else if (sz_half) begin
            sel_c   = lsb[1] ? 4'b0011 : 4'b1100;
            wdata_c = {2{ex_reg2[15:0]}};
        end else begin
            sel_c   = 4'b1111;
            wdata_c = ex_reg2;
        end

        case (lsb)
            2'd0:    byte_v = rdata_q[31:24];
            2'd1:    byte_v = rdata_q[23:16];
            2'd2:    byte_v = rdata_q[15:8];
            default: byte_v = rdata_q[7:0];
        endcase
        half_v = lsb[1] ? rdata_q[15:0] : rdata_q[31:16];

        if (sz_byte)
            ld_c = {{24{is_signed & byte_v[7]}}, byte_v};
        else if (sz_half)
            ld_c = {{16{is_signed & half_v[15]}}, half_v};
        else
            ld_c = rdata_q;
    end

    // Next-state, bus register updates and combinational stage outputs.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        stall_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (go_c && !flush) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {ex_mem_addr[ADDR_W-1:2], 2'b00};
                    sel_d   = sel_c;
                    wdata_d = wdata_c;
                    stall_c = 1'b1;
                end
            end
            BUSY: begin
                stall_c = !flush;
                if (dbus.ack) begin
                    req_d = 1'b0;
                    // A flush landing on the ack cycle just drops the result.
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                        if (!we_q)
                            rdata_d = dbus.rdata;
                    end
                end else if (flush) begin
                    state_d = ABORT;
                end
            end
            DONE: begin
                if (flush || !stall[4])
                    state_d = IDLE;
            end
            ABORT: begin
                stall_c = go_c && !flush;
                if (dbus.ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        mem_wd    = ex_wd;
        mem_wreg  = ex_wreg;
        mem_wdata = ex_wdata;
        if (state_q == DONE) begin
            if (is_load)
                mem_wdata = ld_c;
        end else if (is_load || is_store) begin
            mem_wreg  = 1'b0;
            mem_wdata = 32'd0;
        end
        if (flush)
            mem_wreg = 1'b0;
        misalign = mis_c;
        stallreq = stall_c;

        if (!rst) begin
            mem_wd    = 5'd0;
            mem_wreg  = 1'b0;
            mem_wdata = 32'd0;
            misalign  = 1'b0;
            stallreq  = 1'b0;
        end
    end

    // State and bus registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
